// File: rtl/timer_dev_if.sv
// Bus bundle between the system bridge and one timer_dev window.
// Latency: reads are combinational; writes land on the clock edge that samples WE.
// Backpressure: none; every access completes in its own cycle.
//
// Signals:
//   Addr  byte address from the bridge; Addr[3:2] picks the register
//   WE    write strobe, qualified by the window hit inside the device
//   Din   write data
//   Dout  read data, combinational from Addr[3:2]
//   IRQ   interrupt request toward CP0 HWInt
interface timer_dev_if;
   logic [31:0] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;

   modport master (output Addr, output WE, output Din, input Dout, input IRQ);
   modport slave  (input Addr, input WE, input Din, output Dout, output IRQ);
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with CTRL / PRESET / COUNT registers and an IRQ line.
// Latency: reads are zero-cycle; a write shows on Dout the cycle after its capture edge.
// Backpressure: none; the device accepts a bus access every cycle.
//
// Ports:
//   clk    system clock, all state on the rising edge
//   reset  asynchronous, active-low
//   bus    timer_dev_if.slave (Addr, WE, Din in; Dout, IRQ out)
// Register map by Addr[3:2]: 00 CTRL {IM, Mode[1:0], Enable}, 01 PRESET,
// 10 COUNT (read-only), 11 reads zero. Writes to 10/11 are dropped.
module timer_dev #(
   parameter logic [31:0] BASE = 32'h0000_7F00
) (
   input  logic        clk,
   input  logic        reset,
   timer_dev_if.slave  bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_CNT  = 2'd2;
   localparam logic [1:0] S_INT  = 2'd3;

   logic [3:0]  ctrl;
   logic [31:0] preset;
   logic [31:0] count;
   logic [1:0]  state;
   logic        pend;

   logic hit;
   logic wr_ctrl;
   logic wr_preset;
   logic en;
   logic auto_reload;
   logic expire;
   logic unused_addr_lsb;

   assign hit       = (bus.Addr[31:4] == BASE[31:4]);
   assign wr_ctrl   = bus.WE && hit && (bus.Addr[3:2] == 2'b00);
   assign wr_preset = bus.WE && hit && (bus.Addr[3:2] == 2'b01);
   assign unused_addr_lsb = ^bus.Addr[1:0];

   assign en          = ctrl[0];
   // Mode 1x behaves as one-shot, so only the exact 01 pattern reloads.
   assign auto_reload = (ctrl[2:1] == 2'b01);
   // The edge that moves CNT -> INT; pend is set on this edge.
   assign expire      = (state == S_CNT) && en && (count <= 32'd1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl   <= 4'd0;
         preset <= 32'd0;
         count  <= 32'd0;
         state  <= S_IDLE;
         pend   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (en) state <= S_LOAD;
            end
            S_LOAD: begin
               count <= preset;
               state <= S_CNT;
            end
            S_CNT: begin
               if (!en) begin
                  state <= S_IDLE;
               end else if (count > 32'd1) begin
                  count <= count - 32'd1;
               end else begin
                  // PRESET of 0 or 1 both land here; COUNT floors at zero.
                  count <= 32'd0;
                  state <= S_INT;
               end
            end
            S_INT: begin
               if (auto_reload) state <= S_LOAD;
               else             state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase

         // A CPU write to CTRL on the same edge the one-shot clears Enable
         // takes the whole register, Enable included.
         if (wr_ctrl)
            ctrl <= bus.Din[3:0];
         else if ((state == S_INT) && !auto_reload)
            ctrl[0] <= 1'b0;

         // A fresh expiry outranks a coincident CTRL write so the event is
         // never silently lost; auto-reload drops pend after its INT cycle.
         if (expire)
            pend <= 1'b1;
         else if (wr_ctrl || ((state == S_INT) && auto_reload))
            pend <= 1'b0;

         if (wr_preset)
            preset <= bus.Din;
      end
   end

   always_comb begin
      bus.Dout = 32'd0;
      case (bus.Addr[3:2])
         2'b00:   bus.Dout = {28'd0, ctrl};
         2'b01:   bus.Dout = preset;
         2'b10:   bus.Dout = count;
         default: bus.Dout = 32'd0;
      endcase
   end

   // Driven only from registers, so Din can never glitch the interrupt line.
   assign bus.IRQ = pend & ctrl[3];

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped countdown timer that responds to the CPU's data-memory bus in the 0x7F00 and 0x7F10 windows; two instances sit behind the system bridge, one per window. It is the device end of the accesses the memory-operation checker already screens: it receives only aligned word stores and word loads to offsets 0x0–0xB. It exposes CTRL, PRESET and COUNT registers, counts down under a four-state FSM, and raises an interrupt request to CP0.

## Interface
- BASE, 32'h00007F00, window base; hit when Addr[31:4] == BASE[31:4]
- clk  input  1  system clock; all state on rising edge
- reset  input  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
- Addr  input  32  byte address from bridge; Addr[3:2] selects register
- WE  input  1  write strobe; write occurs when WE & hit at rising edge
- Din  input  32  write data
- Dout  output  32  read data, combinational from Addr[3:2]
- IRQ  output  1  interrupt request to CP0 HWInt

## Operation
- Register map (Addr[3:2]): 00 CTRL, 01 PRESET, 10 COUNT (read-only), 11 reads 0. Writes to 10/11 ignored.
- CTRL bits: [0] Enable, [2:1] Mode (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (interrupt mask, 1 = enabled); [31:4] read 0, writes to them discarded.
- PRESET: full 32-bit, read/write. Writing PRESET does not disturb a running COUNT; it takes effect at the next LOAD.
- FSM states IDLE, LOAD, CNT, INT:
  - IDLE: COUNT holds. Enable=1 -> LOAD.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT: Enable=0 -> IDLE (COUNT holds). Else COUNT > 1: COUNT <= COUNT-1, stay. Else (COUNT ≤ 1): COUNT <= 0, pend <= 1, -> INT.
  - INT (one cycle): Mode 00: Enable <= 0, -> IDLE. Mode 01: pend <= 0, -> LOAD.
- pend (internal): set on CNT->INT. Mode 00: stays set until any CTRL write. Mode 01: high exactly for the INT cycle.
- IRQ = pend & IM, registered state only (no combinational path from Din).
- COUNT arithmetic is 32-bit unsigned; never wraps below 0.
- CPU write to CTRL in the same cycle the FSM clears Enable (INT, Mode 00): the CPU write wins entirely.
- CTRL write with Enable=0 during LOAD/CNT: FSM goes to IDLE on the following edge; COUNT frozen at its current value.

## Timing
- Reset (async assert): CTRL=0, PRESET=0, COUNT=0, state=IDLE, pend=0, so IRQ=0 and Dout=0 for every address. Deassertion is synchronous to clk; first write accepted on the first rising edge after deassertion.
- Reads: zero latency; Dout reflects register contents after the most recent edge.
- Writes: visible on Dout the cycle after the edge that captures them.
- Enable written at edge E0: LOAD after E1, COUNT=PRESET after E2, IRQ (if IM=1) after E(N+2) for PRESET=N≥1; PRESET=0 behaves as PRESET=1.
- Mode 01 period: N+2 cycles between successive INT cycles; IRQ pulse width exactly 1 cycle.
- Mode 00: IRQ stays high until the edge that captures a CTRL write, low the cycle after.
- Reset asserted mid-count: all state returns to reset values immediately, no IRQ glitch after release.

## Test plan
- Reset: hold reset=0 for 3 cycles -> IRQ=0, Dout=0 at offsets 0x0/0x4/0x8; release; read 0x7F00 -> 0.
- One-shot: PRESET=5, CTRL=0x9 -> COUNT reads 5,4,3,2,1,0; IRQ rises 7 cycles after CTRL edge; CTRL reads 0x8; IRQ stays high until CTRL write 0x0, then low next cycle.
- Auto-reload: PRESET=3, CTRL=0xB -> IRQ 1-cycle pulses every 5 cycles for ≥3 periods; COUNT sequence 3,2,1,0,(LOAD) repeats.
- Mask/disable: PRESET=4, CTRL=0x1 -> reaches INT with IRQ=0 throughout; separately CTRL=0x9 then CTRL=0x8 after COUNT=2 -> COUNT frozen at 2 (or 1 by edge ordering, checked against model), no IRQ.
- Boundaries: PRESET=0 with CTRL=0x9 -> IRQ 3 cycles after enable; write to COUNT offset and CTRL[31:4] ignored; PRESET write during CNT does not change current COUNT, next LOAD uses new value.
- Async reset at COUNT=2 with auto-reload -> all registers 0 in same cycle, IRQ=0; BASE=0x7F10 instance ignores writes to 0x7F00.
